// File: rtl/counter_checker.sv
// counter_checker: locks onto a counter value stream, then flags and counts every
// out-of-sequence sample against the sequence an identical counter would produce.
module counter_checker #(
  parameter int DATA_WIDTH   = 8,
  parameter int COUNT_FROM   = 0,
  parameter int COUNT_TO     = 255,
  parameter int STEP         = 1,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  locked,
  output logic                  error,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [DATA_WIDTH-1:0] expected
);
  localparam int MW = $clog2(LOCK_COUNT) + 1;
  localparam int UW = $clog2(UNLOCK_COUNT) + 1;
  localparam logic [DATA_WIDTH:0] FROM = (DATA_WIDTH+1)'(COUNT_FROM);
  localparam logic [DATA_WIDTH:0] TO   = (DATA_WIDTH+1)'(COUNT_TO);
  localparam logic [DATA_WIDTH:0] INC  = (DATA_WIDTH+1)'(STEP);
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  logic [1:0]            state;
  logic [MW-1:0]         match, match_inc;
  logic [UW-1:0]         miss, miss_inc;
  logic [DATA_WIDTH:0]   sum_din, sum_exp;
  logic [DATA_WIDTH-1:0] next_din, next_exp;
  logic                  hit, legal;
  // sums carry an extra bit so a step past COUNT_TO wraps to COUNT_FROM, never modulo 2^W
  always_comb begin
    sum_din   = {1'b0, din} + INC;
    sum_exp   = {1'b0, expected} + INC;
    next_din  = sum_din <= TO ? sum_din[DATA_WIDTH-1:0] : FROM[DATA_WIDTH-1:0];
    next_exp  = sum_exp <= TO ? sum_exp[DATA_WIDTH-1:0] : FROM[DATA_WIDTH-1:0];
    legal     = ({1'b0, din} + (DATA_WIDTH+1)'(1)) > FROM && {1'b0, din} <= TO;
    hit       = din == expected;
    match_inc = match + MW'(1);
    miss_inc  = miss + UW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      match     <= '0;
      miss      <= '0;
      error     <= 1'b0;
      err_count <= '0;
      expected  <= FROM[DATA_WIDTH-1:0];
    end else begin
      error <= 1'b0;
      if (en)
        case (state)
          SEARCH:
            if (legal) begin
              expected <= next_din;
              match    <= '0;
              state    <= VERIFY;
            end
          VERIFY:
            if (hit) begin
              expected <= next_exp;
              match    <= match_inc;
              if (match_inc == MW'(LOCK_COUNT)) begin
                state <= LOCKED;
                miss  <= '0;
              end
            end else if (legal) begin
              expected <= next_din;
              match    <= '0;
            end else begin
              match <= '0;
              state <= SEARCH;
            end
          default: begin
            expected <= next_exp;
            if (hit) miss <= '0;
            else begin
              error <= 1'b1;
              miss  <= miss_inc;
              if (~&err_count) err_count <= err_count + ERR_WIDTH'(1);
              if (miss_inc == UW'(UNLOCK_COUNT)) state <= SEARCH;
            end
          end
        endcase
    end
  end
  assign locked = state == LOCKED;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: scoreboard bench over three checker configurations.
module tb_counter_checker;
  typedef struct packed {
    logic        l;
    logic        e;
    logic [15:0] c;
    logic [7:0]  x;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic [7:0] din0 = '0, din1 = '0, din2 = '0;
  logic locked0, error0, locked1, error1, locked2, error2;
  logic [15:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [7:0] exp0, exp1, exp2;
  exp_t q[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  counter_checker dut0 (
    .clk(clk), .rst(rst), .en(en0), .din(din0),
    .locked(locked0), .error(error0), .err_count(cnt0), .expected(exp0)
  );
  counter_checker #(.COUNT_FROM(10), .COUNT_TO(20), .STEP(3)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .din(din1),
    .locked(locked1), .error(error1), .err_count(cnt1), .expected(exp1)
  );
  counter_checker #(.ERR_WIDTH(2), .UNLOCK_COUNT(8)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .din(din2),
    .locked(locked2), .error(error2), .err_count(cnt2), .expected(exp2)
  );

  function automatic exp_t obs(input int k);
    return k == 0 ? {locked0, error0, cnt0, exp0}
         : k == 1 ? {locked1, error1, cnt1, exp1}
         : {locked2, error2, 14'd0, cnt2, exp2};
  endfunction

  task automatic drive(input int k, input logic e, input logic [7:0] v);
    en0 = e && k == 0;
    en1 = e && k == 1;
    en2 = e && k == 2;
    din0 = v;
    din1 = v;
    din2 = v;
  endtask

  task automatic do_reset(input int n);
    drive(0, 1'b0, 8'd0);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got, want;
    do_reset(2);
    for (int k = 0; k < 3; k++) q.push_back({1'b0, 1'b0, 16'd0, (k == 1) ? 8'd10 : 8'd0});
    for (int k = 0; k < 3; k++) begin
      got = obs(k); want = q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL reset dut%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_lock();
    exp_t got, want;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, 8'(i));
      q.push_back({i >= 4, 1'b0, 16'd0, 8'(i + 1)});
      @(posedge clk); #1;
      got = obs(0); want = q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL lock[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_wrap();
    exp_t got, want;
    int d[10] = '{248, 249, 250, 251, 252, 253, 254, 255, 0, 1};
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, 8'(d[i]));
      q.push_back({i >= 4, 1'b0, 16'd0, (d[i] == 255) ? 8'd0 : 8'(d[i] + 1)});
      @(posedge clk); #1;
      got = obs(0); want = q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL wrap[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_glitch();
    exp_t got, want;
    int d[10] = '{45, 46, 47, 48, 49, 50, 51, 99, 53, 54};
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, 8'(d[i]));
      q.push_back({i >= 4, d[i] == 99, (i >= 7) ? 16'd1 : 16'd0, (d[i] == 99) ? 8'd53 : 8'(d[i] + 1)});
      @(posedge clk); #1;
      got = obs(0); want = q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL glitch[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_unlock();
    exp_t got, want;
    int d[14]  = '{45, 46, 47, 48, 49, 50, 200, 7, 7, 40, 41, 42, 43, 44};
    int lk[14] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    int er[14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    int cn[14] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 3, 3};
    int xp[14] = '{46, 47, 48, 49, 50, 51, 52, 53, 54, 41, 42, 43, 44, 45};
    do_reset(1);
    for (int i = 0; i < 14; i++) begin
      drive(0, 1'b1, 8'(d[i]));
      q.push_back({1'(lk[i]), 1'(er[i]), 16'(cn[i]), 8'(xp[i])});
      @(posedge clk); #1;
      got = obs(0); want = q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL unlock[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_en_gaps();
    exp_t got, want;
    int ev[8] = '{1, 0, 1, 0, 1, 1, 0, 1};
    int d[8]  = '{45, 99, 46, 0, 47, 99, 0, 49};
    int er[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int cn[8] = '{3, 3, 3, 3, 3, 4, 4, 4};
    int xp[8] = '{46, 46, 47, 47, 48, 49, 49, 50};
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'(ev[i]), 8'(d[i]));
      q.push_back({1'b1, 1'(er[i]), 16'(cn[i]), 8'(xp[i])});
      @(posedge clk); #1;
      got = obs(0); want = q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL en_gap[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t got, want;
    drive(0, 1'b1, 8'd50);
    rst = 1'b1;
    q.push_back({1'b0, 1'b0, 16'd0, 8'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    got = obs(0); want = q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL reset_mid got=%h want=%h", got, want); end
  endtask

  task automatic test_wrap_step();
    exp_t got, want;
    int d[9] = '{10, 13, 16, 19, 10, 13, 16, 19, 10};
    do_reset(1);
    for (int i = 0; i < 9; i++) begin
      drive(1, 1'b1, 8'(d[i]));
      q.push_back({i >= 4, 1'b0, 16'd0, (d[i] + 3 > 20) ? 8'd10 : 8'(d[i] + 3)});
      @(posedge clk); #1;
      got = obs(1); want = q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL wrap_step[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_illegal();
    exp_t got, want;
    int d[7]  = '{30, 5, 10, 13, 16, 19, 10};
    int xp[7] = '{10, 10, 13, 16, 19, 10, 13};
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      drive(1, 1'b1, 8'(d[i]));
      q.push_back({i == 6, 1'b0, 16'd0, 8'(xp[i])});
      @(posedge clk); #1;
      got = obs(1); want = q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL illegal[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_saturation();
    exp_t got, want;
    int d[11]  = '{0, 1, 2, 3, 4, 100, 100, 100, 100, 100, 10};
    int cn[11] = '{0, 0, 0, 0, 0, 1, 2, 3, 3, 3, 3};
    do_reset(1);
    for (int i = 0; i < 11; i++) begin
      drive(2, 1'b1, 8'(d[i]));
      q.push_back({i >= 4, d[i] == 100, 16'(cn[i]), 8'(i + 1)});
      @(posedge clk); #1;
      got = obs(2); want = q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL saturate[%0d] got=%h want=%h", i, got, want); end
    end
    drive(2, 1'b1, 8'd11);
    rst = 1'b1;
    q.push_back({1'b0, 1'b0, 16'd0, 8'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    got = obs(2); want = q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL saturate_reset got=%h want=%h", got, want); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_glitch();
    test_unlock();
    test_en_gaps();
    test_reset_mid();
    test_wrap_step();
    test_illegal();
    test_saturation();
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
